// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder built around one 4-bit lookahead slice.
// It adds one nibble per cycle, LSB first, and keeps the slice carry in a register.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             last;

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] s4;
    logic       c1, c2, c3, c4;

    assign last = (idx == IW'(N - 1));

    // Lookahead slice on the current low nibble of the operand shifters.
    always_comb begin
        p  = a_sh[3:0] ^ b_sh[3:0];
        g  = a_sh[3:0] & b_sh[3:0];
        c1 = g[0] | (p[0] & carry);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & carry);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & carry);
        s4 = p ^ {c3, c2, c1, carry};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand shifters, carry chain, index and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                idx   <= '0;
            end else if (state == RUN) begin
                sum[{idx, 2'b00} +: 4] <= s4;
                a_sh  <= a_sh >> 4;
                b_sh  <= b_sh >> 4;
                carry <= c4;
                idx   <= idx + IW'(1);
                if (last) begin
                    cout     <= c4;
                    overflow <= c3 ^ c4;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=32.
// Results are compared with plain integer addition and the signed-sign rule.
module tb_nibble_serial_adder;

    logic clk;
    logic rst;

    logic        iv16, ir16, ov16, or16, co16, of16, bz16, ci16;
    logic [15:0] a16, b16, s16;

    logic        iv32, ir32, ov32, or32, co32, of32, bz32, ci32;
    logic [31:0] a32, b32, s32;

    int tests;
    int fails;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(ci16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .overflow(of16),
        .busy(bz16)
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(ci32),
        .out_valid(ov32), .out_ready(or32),
        .sum(s32), .cout(co32), .overflow(of32),
        .busy(bz32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input int stall,
                         output logic [15:0] s, output logic co,
                         output logic of, output int lat);
        int w;
        w = 0;
        while (!ir16 && w < 50) begin @(posedge clk); #1; w++; end
        a16 = ia; b16 = ib; ci16 = ic; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        s = s16; co = co16; of = of16;
        for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    task automatic run32(input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input int stall,
                         output logic [31:0] s, output logic co,
                         output logic of, output int lat);
        int w;
        w = 0;
        while (!ir32 && w < 50) begin @(posedge clk); #1; w++; end
        a32 = ia; b32 = ib; ci32 = ic; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 50) begin @(posedge clk); #1; lat++; end
        s = s32; co = co32; of = of32;
        for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0 || bz16 !== 1'b0 ||
            s16 !== 16'h0 || co16 !== 1'b0 || of16 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ir=%b ov=%b bz=%b s=%h co=%b of=%b, want 1 0 0 0000 0 0",
                     ir16, ov16, bz16, s16, co16, of16);
        end
        tests++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0 || s32 !== 32'h0) begin
            fails++;
            $display("FAIL reset_state32: ir=%b ov=%b s=%h, want 1 0 0", ir32, ov32, s32);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s; logic co, of; int lat;
        a16 = 16'h1111; b16 = 16'h1111; ci16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_before", 64'(bz16), 64'd1);
        chk("mid_sum_partial", 64'(s16), 64'h0002);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(ov16), 64'd0);
        chk("mid_rst_busy", 64'(bz16), 64'd0);
        chk("mid_rst_sum", 64'(s16), 64'd0);
        chk("mid_rst_in_ready", 64'(ir16), 64'd1);
        @(posedge clk); #1;
        chk("mid_rst_no_valid", 64'(ov16), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run16(16'h0001, 16'h0001, 1'b0, 0, s, co, of, lat);
        chk("after_rst_sum", 64'(s), 64'h0002);
        chk("after_rst_lat", 64'(lat), 64'd4);
    endtask

    task automatic test_directed();
        logic [15:0] s; logic co, of; int lat;
        or16 = 1'b1;
        run16(16'hFFFF, 16'h0001, 1'b0, 0, s, co, of, lat);
        chk("chain_lat", 64'(lat), 64'd4);
        chk("chain_sum", 64'(s), 64'h0000);
        chk("chain_cout", 64'(co), 64'd1);
        chk("chain_ovf", 64'(of), 64'd0);
        chk("chain_in_ready_back", 64'(ir16), 64'd1);
        run16(16'h7FFF, 16'h0001, 1'b0, 0, s, co, of, lat);
        chk("ovf_pos_sum", 64'(s), 64'h8000);
        chk("ovf_pos_cout", 64'(co), 64'd0);
        chk("ovf_pos_ovf", 64'(of), 64'd1);
        run16(16'h8000, 16'h8000, 1'b0, 1, s, co, of, lat);
        chk("ovf_neg_sum", 64'(s), 64'h0000);
        chk("ovf_neg_cout", 64'(co), 64'd1);
        chk("ovf_neg_ovf", 64'(of), 64'd1);
        run16(16'h0000, 16'hFFFF, 1'b1, 0, s, co, of, lat);
        chk("cin_sum", 64'(s), 64'h0000);
        chk("cin_cout", 64'(co), 64'd1);
        chk("cin_ovf", 64'(of), 64'd0);
        run16(16'h1234, 16'h4321, 1'b1, 2, s, co, of, lat);
        chk("cin2_sum", 64'(s), 64'h5556);
        chk("cin2_cout", 64'(co), 64'd0);
    endtask

    task automatic test_backpressure();
        logic [15:0] s; logic co; int lat;
        or16 = 1'b0;
        a16 = 16'hABCD; b16 = 16'h1357; ci16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("bp_lat", 64'(lat), 64'd4);
        chk("bp_sum", 64'(s16), 64'hBF24);
        s = s16; co = co16;
        for (int i = 0; i < 5; i++) begin
            iv16 = ~iv16;
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
            @(posedge clk); #1;
            tests++;
            if (ir16 !== 1'b0 || ov16 !== 1'b1 || s16 !== s || co16 !== co || bz16 !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: ir=%b ov=%b bz=%b s=%h co=%b, want 0 1 1 %h %b",
                         i, ir16, ov16, bz16, s16, co16, s, co);
            end
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        chk("bp_release_in_ready", 64'(ir16), 64'd1);
        chk("bp_release_valid", 64'(ov16), 64'd0);
        @(posedge clk); #1;
        chk("bp_not_accepted", 64'(bz16), 64'd0);
    endtask

    task automatic test_random16();
        logic [15:0] ia, ib, s; logic ic, co, of; int lat;
        logic [16:0] r; logic exp_of;
        for (int k = 0; k < 1000; k++) begin
            ia = 16'($urandom); ib = 16'($urandom); ic = 1'($urandom);
            if (k % 7 == 0) ia = 16'hFFFF;
            or16 = 1'($urandom_range(0, 1));
            run16(ia, ib, ic, $urandom_range(0, 3), s, co, of, lat);
            r = 17'(ia) + 17'(ib) + 17'(ic);
            exp_of = (ia[15] == ib[15]) && (r[15] != ia[15]);
            tests++;
            if ({co, s} !== r || of !== exp_of || lat != 4) begin
                fails++;
                $display("FAIL rand16 %h+%h+%b: got c=%b s=%h o=%b lat=%0d, want c=%b s=%h o=%b lat=4",
                         ia, ib, ic, co, s, of, lat, r[16], r[15:0], exp_of);
            end
        end
        or16 = 1'b0;
    endtask

    task automatic test_random32();
        logic [31:0] ia, ib, s; logic ic, co, of; int lat;
        logic [32:0] r; logic exp_of;
        for (int k = 0; k < 1000; k++) begin
            ia = $urandom; ib = $urandom; ic = 1'($urandom);
            if (k % 9 == 0) ib = ~ia;
            or32 = 1'($urandom_range(0, 1));
            run32(ia, ib, ic, $urandom_range(0, 3), s, co, of, lat);
            r = 33'(ia) + 33'(ib) + 33'(ic);
            exp_of = (ia[31] == ib[31]) && (r[31] != ia[31]);
            tests++;
            if ({co, s} !== r || of !== exp_of || lat != 8) begin
                fails++;
                $display("FAIL rand32 %h+%h+%b: got c=%b s=%h o=%b lat=%0d, want c=%b s=%h o=%b lat=8",
                         ia, ib, ic, co, s, of, lat, r[32], r[31:0], exp_of);
            end
        end
        or32 = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
        iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0;
        #12;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset_mid();
        test_directed();
        test_backpressure();
        test_random16();
        test_random32();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
